irq_encoder: RTL

IRQ_ENCODER -- requirements
Module: irq_encoder

---
 rtl/irq_encoder_pkg.sv | 12 +
 rtl/irq_encoder_if.sv | 9 +
 rtl/irq_encoder_prienc_8.sv | 11 +
 rtl/irq_encoder.sv | 94 +++++++++
 4 files changed

// File: rtl/irq_encoder_pkg.sv
// Shared constants and FSM encoding for the interrupt encoder.
package irq_encoder_pkg;
  localparam int NIRQ        = 8;
  localparam int VEC_W       = 3;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_GAP  = 3'd2
  } state_e;
endpackage

// File: rtl/irq_encoder_if.sv
// CPU-side request/acknowledge handshake of the interrupt encoder.
interface irq_encoder_if import irq_encoder_pkg::*; ();
  logic             req;
  logic [VEC_W-1:0] vec;
  logic             ack;

  modport master (output req, output vec, input ack);
  modport slave  (input req, input vec, output ack);
endinterface

// File: rtl/irq_encoder_prienc_8.sv
// 8-input priority encoder: index of the highest set bit; zero input gives 0.
module prienc_8 (
  input  logic [7:0] in_i,
  output logic [2:0] idx_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < 8; i++)
      if (in_i[i]) idx_o = 3'(i);
  end
endmodule

// File: rtl/irq_encoder.sv
// Synchronizes raw interrupt lines, latches rising edges as pending, and
// presents the highest-index eligible line to the CPU with a req/ack handshake.
module irq_encoder import irq_encoder_pkg::*; (
  input  logic             ph1,
  input  logic             reset_b,
  input  logic [NIRQ-1:0]  irq,
  input  logic             mask_we,
  input  logic [NIRQ-1:0]  mask_d,
  output logic [NIRQ-1:0]  mask_q,
  output logic [NIRQ-1:0]  pend_q,
  irq_encoder_if.master    cpu
);
  localparam logic [VEC_W-1:0] TOP = VEC_W'(NIRQ-1);

  state_e                 state_q, state_d;
  logic [NIRQ-1:0]        s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [NIRQ-1:0]        armed_q, armed_d, pend_d, mask_sel_d;
  logic [SYNC_STAGES-1:0] vld_pipe_q, vld_pipe_d;
  logic [VEC_W-1:0]       vec_q, vec_d;

  logic [NIRQ-1:0]  set, clr, elig;
  logic [VEC_W-1:0] top_idx, svc_idx;
  logic             req, ack_fire, latch;

  assign elig = pend_q & mask_q;

  prienc_8 u_prienc (.in_i(elig), .idx_o(top_idx));

  // State register
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|elig)   state_d = ST_REQ;
      ST_REQ:  if (cpu.ack) state_d = ST_GAP;
      ST_GAP:               state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req      = (state_q == ST_REQ);
    ack_fire = (state_q == ST_REQ) && cpu.ack;
    latch    = (state_q == ST_IDLE) && (|elig);
  end

  assign cpu.req = req;
  assign cpu.vec = vec_q;

  // A line is armed only once the sync pipe carries real samples and has
  // shown it low, so a line held high through reset cannot fake an edge.
  always_comb begin
    s1_d       = irq;
    s2_d       = s1_q;
    prev_d     = s2_q;
    vld_pipe_d = {vld_pipe_q[SYNC_STAGES-2:0], 1'b1};
    armed_d    = armed_q | (~s2_q & {NIRQ{vld_pipe_q[SYNC_STAGES-1]}});
    set        = armed_q & s2_q & ~prev_q;
    svc_idx    = TOP - vec_q;
    clr        = '0;
    if (ack_fire) clr[svc_idx] = 1'b1;
    pend_d     = (pend_q & ~clr) | set;
    mask_sel_d = mask_we ? mask_d : mask_q;
    vec_d      = latch ? (TOP - top_idx) : vec_q;
  end

  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      vld_pipe_q <= '0;
      armed_q    <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      vec_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      prev_q     <= prev_d;
      vld_pipe_q <= vld_pipe_d;
      armed_q    <= armed_d;
      pend_q     <= pend_d;
      mask_q     <= mask_sel_d;
      vec_q      <= vec_d;
    end
  end
endmodule
